// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling through a two-flop synchronizer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       dout_valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             rx_q1;
   logic             rx_s;
`ifdef UART_RX_PARITY_EN
   logic             par_bit;
   logic             parity_err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         rx_q1      <= 1'b1;
         rx_s       <= 1'b1;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit      <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_q1      <= rx;
         rx_s       <= rx_q1;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rx_s) state <= START;
            end
            // A start bit that is no longer low at its midpoint is a glitch.
            START: begin
               if (cnt == HALF_M1) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  par_bit <= rx_s;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            // Leaving at mid stop bit leaves room for a back-to-back start edge.
            STOP: begin
               if (cnt == FULL_M1) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
`ifdef UART_RX_PARITY_EN
                     if (^{shreg, par_bit}) begin
                        parity_err_q <= 1'b1;
                     end else begin
                        dout       <= shreg;
                        dout_valid <= 1'b1;
                     end
`else
                     dout       <= shreg;
                     dout_valid <= 1'b1;
`endif
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               cnt <= '0;
               if (rx_s) state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; received bytes are
// checked against a queue filled as each good frame is driven.
module tb_uart_rx;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + (NBITS - 10) * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] dout;
   logic       dout_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;
   logic [2:0] dbg_state;

   uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .dout       (dout),
      .dout_valid (dout_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   int         dv_cnt = 0;
   int         fe_cnt = 0;
   int         pe_cnt = 0;
   int         last_dv_cyc = 0;
   int         start_cyc = 0;
   logic       prev_dv = 1'b0;
   logic       prev_fe = 1'b0;
   logic       prev_pe = 1'b0;
   int         base_dv, base_fe, base_pe;
   logic [7:0] exp_b;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: strobe accounting and scoreboard pops.
   always @(negedge clk) begin
      if (dout_valid === 1'b1) begin
         dv_cnt++;
         last_dv_cyc = cyc;
         check("dv_one_cycle", {31'd0, prev_dv}, 32'd0);
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL dv_unexpected observed=%0h expected=none", dout);
         end
         if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("dout_byte", {24'd0, dout}, {24'd0, exp_b});
         end
      end
      if (frame_err === 1'b1) begin
         fe_cnt++;
         check("fe_one_cycle", {31'd0, prev_fe}, 32'd0);
      end
      if (parity_err === 1'b1) begin
         pe_cnt++;
         check("pe_one_cycle", {31'd0, prev_pe}, 32'd0);
      end
      prev_dv = dout_valid;
      prev_fe = frame_err;
      prev_pe = parity_err;
   end

   function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d, input logic stop_b,
                                                   input logic par_flip);
`ifdef UART_RX_PARITY_EN
      return {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
      return {stop_b, d, par_flip & 1'b0};
`endif
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
      logic [NBITS-1:0] bits;
      bits = frame_bits(d, stop_b, par_flip);
      start_cyc = cyc;
      for (int i = 0; i < NBITS; i++) begin
         rx = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [NBITS-1:0] rbits;

      // Reset state
      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_dout", {24'd0, dout}, 32'h00);
      check("rst_dv", {31'd0, dout_valid}, 32'd0);
      check("rst_fe", {31'd0, frame_err}, 32'd0);
      check("rst_pe", {31'd0, parity_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, 32'd0);
      @(posedge clk);
      #1;

      // Single frame 0xA5 with latency check
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      check("a5_latency", {31'd0, ((last_dv_cyc - start_cyc) >= LAT - 1) &&
                                  ((last_dv_cyc - start_cyc) <= LAT + 1)}, 32'd1);
      check("a5_dv_count", dv_cnt, 32'd1);
      @(negedge clk);
      check("a5_busy_after", {31'd0, busy}, 32'd0);
      check("a5_dout_hold", {24'd0, dout}, 32'hA5);
      @(posedge clk);
      #1;

      // False start: 4-cycle glitch
      base_dv = dv_cnt;
      base_fe = fe_cnt;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      @(negedge clk);
      check("glitch_busy_high", {31'd0, busy}, 32'd1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_low", {31'd0, busy}, 32'd0);
      check("glitch_no_dv", dv_cnt, base_dv);
      check("glitch_no_fe", fe_cnt, base_fe);
      @(posedge clk);
      #1;

      // Back-to-back 0x00 then 0xFF
      base_dv = dv_cnt;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      check("b2b_dv_count", dv_cnt, base_dv + 2);
      check("b2b_dout", {24'd0, dout}, 32'hFF);

      // Framing error followed by a long break
      base_fe = fe_cnt;
      base_dv = dv_cnt;
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("fe_count", fe_cnt, base_fe + 1);
      check("fe_no_dv", dv_cnt, base_dv);
      check("fe_dout_kept", {24'd0, dout}, 32'hFF);
      check("fe_wait_high", {29'd0, dbg_state}, 32'd5);
      check("fe_busy", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("fe_back_idle", {29'd0, dbg_state}, 32'd0);
      @(posedge clk);
      #1;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0);
      check("after_fe_dout", {24'd0, dout}, 32'h81);

      // Reset in the middle of data bit 4 of frame 0xF1
      base_dv = dv_cnt;
      base_fe = fe_cnt;
      rbits = frame_bits(8'hF1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rx = rbits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx = rbits[5];
      repeat (CPB / 2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_dout", {24'd0, dout}, 32'h00);
      check("midrst_dv", {31'd0, dout_valid}, 32'd0);
      check("midrst_fe", {31'd0, frame_err}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (CPB / 2 - 1) @(posedge clk);
      #1;
      for (int i = 6; i < NBITS; i++) begin
         rx = rbits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      repeat (CPB) @(posedge clk);
      #1;
      check("midrst_no_dv", dv_cnt, base_dv);
      check("midrst_no_fe", fe_cnt, base_fe);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0);
      check("midrst_next_dout", {24'd0, dout}, 32'h5A);
      check("midrst_next_dv", dv_cnt, base_dv + 1);

`ifdef UART_RX_PARITY_EN
      // Even parity: good then corrupted parity bit
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      check("par_good_dout", {24'd0, dout}, 32'h07);
      base_dv = dv_cnt;
      base_pe = pe_cnt;
      send_frame(8'h07, 1'b1, 1'b1);
      check("par_bad_pe", pe_cnt, base_pe + 1);
      check("par_bad_no_dv", dv_cnt, base_dv);
      check("par_bad_dout", {24'd0, dout}, 32'h07);
`else
      base_pe = 0;
      check("no_parity_err", pe_cnt, base_pe);
`endif

      repeat (5) @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
